// File: rtl/dpram_loader.sv
// Boot loader: parses SYNC/addr/count/data/checksum byte frames and
// writes each assembled 32-bit word into the program RAM write port.
module dpram_loader #(
  parameter int         ADDR_W = 12,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_CNT_H,
    S_CNT_L,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [31:0]       data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  logic              acc;
  logic              good;
  logic [15:0]       hl;
  logic [31:0]       shifted;

  assign rx_ready = (state_q != S_WRITE) && (state_q != S_FIN);
  assign acc      = rx_valid && rx_ready;
  assign hl       = {hi_q, rx_data};
  // Little-endian assembly: first byte ends up in bits 7:0
  assign shifted  = {rx_data, word_q[31:8]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    hi_d    = hi_q;
    chk_d   = chk_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    hold_d  = hold_q;
    good    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc && rx_data == SYNC) begin
          state_d = S_ADDR_H;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          chk_d   = 8'h00;
        end
      end
      S_ADDR_H: begin
        if (acc) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (acc) begin
          addr_d  = hl[ADDR_W-1:0];
          chk_d   = chk_q ^ rx_data;
          state_d = S_CNT_H;
        end
      end
      S_CNT_H: begin
        if (acc) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_CNT_L;
        end
      end
      S_CNT_L: begin
        if (acc) begin
          cnt_d   = hl;
          idx_d   = 2'd0;
          chk_d   = chk_q ^ rx_data;
          state_d = (hl == 16'd0) ? S_CHK : S_DATA;
        end
      end
      S_DATA: begin
        if (acc) begin
          word_d = shifted;
          idx_d  = idx_q + 2'd1;
          chk_d  = chk_q ^ rx_data;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            data_d  = shifted;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - 16'd1;
        idx_d   = 2'd0;
        state_d = (cnt_q == 16'd1) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (acc) begin
          good    = (rx_data == chk_q);
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = good;
          err_d   = ~good;
          hold_d  = ~good;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      hi_q    <= '0;
      chk_q   <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      hi_q    <= hi_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_we   = we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = err_q;
  assign cpu_hold = hold_q;

endmodule
